alu_hs_core: RTL



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_hs_core_if.sv | 27 ++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_hs_core.sv | 104 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the handshaked ALU core.
// Opcode and FSM state encodings live here.
package alu_pkg;

    localparam int WIDTH_DEF   = 64;
    localparam int SHAMT_W_DEF = 6;
    localparam int OP_W_DEF    = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_hs_core_if.sv
// Request/response handshake bundle for the ALU core.
// slave = core side, master = requester/consumer side.
interface alu_hs_core_if #(
    parameter int WIDTH = 64,
    parameter int OP_W  = 3
);

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [OP_W-1:0]  op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] res;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in1, in2, op, in_valid, out_ready,
        output in_ready, res, out_valid
    );

    modport master (
        output in1, in2, op, in_valid, out_ready,
        input  in_ready, res, out_valid
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one bit per cycle.
// o_done/o_product are valid combinationally on the last iteration.
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_last;

    assign w_acc_nxt = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_last    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_busy    = r_busy;
    assign o_done    = w_last;
    assign o_product = w_acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_hs_core.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative MUL.
// One transaction in flight; result is registered and held until retired.
module alu_hs_core
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input logic          clk,
    input logic          rst,
    alu_hs_core_if.slave bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_res;
    logic               r_rdy_en;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [WIDTH-1:0]   w_mul_prod;
    logic [WIDTH-1:0]   w_alu;
    logic [SHAMT_W-1:0] w_shamt;
    alu_op_e            w_op;

    // r_rdy_en keeps in_ready low during reset and for the first edge after it
    assign bus.in_ready  = r_rdy_en
                         & ((r_state == S_IDLE)
                         | ((r_state == S_RESP) & bus.out_ready));
    assign bus.out_valid = (r_state == S_RESP);
    assign bus.res       = r_res;

    assign w_op        = alu_op_e'(bus.op);
    assign w_accept    = bus.in_valid & bus.in_ready;
    assign w_is_mul    = (w_op == OP_MUL);
    assign w_mul_start = w_accept & w_is_mul & ~w_mul_busy;
    assign w_shamt     = bus.in2[SHAMT_W-1:0];

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = bus.in1 + bus.in2;
            OP_SUB:  w_alu = bus.in1 - bus.in2;
            OP_AND:  w_alu = bus.in1 & bus.in2;
            OP_OR:   w_alu = bus.in1 | bus.in2;
            OP_XOR:  w_alu = bus.in1 ^ bus.in2;
            OP_SLL:  w_alu = bus.in1 << w_shamt;
            OP_SRL:  w_alu = bus.in1 >> w_shamt;
            default: w_alu = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_mul_start),
        .i_a      (bus.in1),
        .i_b      (bus.in2),
        .o_busy   (w_mul_busy),
        .o_done   (w_mul_done),
        .o_product(w_mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_res    <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= S_CALC;
                        end else begin
                            r_res   <= w_alu;
                            r_state <= S_RESP;
                        end
                    end else if ((r_state == S_RESP) && bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (w_mul_done) begin
                        r_res   <= w_mul_prod;
                        r_state <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
